// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if
// Parallel-side request bundle and serial-line outputs of the UART transmitter.
//   Prescale   : clock cycles per serial bit (0..4 are treated as 5)
//   P_Data     : parallel word to send
//   Data_Valid : request strobe qualifying P_Data
//   PAR_EN     : 1 = parity bit included in the frame
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   TX_OUT     : serial line, idles high
//   Busy       : high while a frame is in progress
// master = requester (register/FIFO read logic), slave = transmitter.
interface uart_tx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [4:0]            Prescale;
  logic [DATA_WIDTH-1:0] P_Data;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output Prescale, P_Data, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  Prescale, P_Data, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core
// UART transmitter: serialises a parallel word LSB first as
// start bit, DATA_WIDTH data bits, optional parity bit, one stop bit.
// Every bit is held for Ps clock cycles, Ps = Prescale clamped to >= 5.
// Ports:
//   CLK   : clock, all logic on the rising edge
//   Reset : synchronous active-high reset
//   bus   : uart_tx_core_if.slave (request inputs, TX_OUT / Busy outputs)
// Frame settings are latched at acceptance so later input changes do not
// disturb the frame in flight. A request presented in the last stop-bit
// cycle starts the next frame without an idle gap.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input logic          CLK,
  input logic          Reset,
  uart_tx_core_if.slave bus
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  logic [4:0]            edge_cnt_r;
  logic [BIT_W-1:0]      bit_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic [4:0]            ps_r;
  logic                  tx_out_r;
  logic                  busy_r;

  logic [4:0]            ps_clamp_s;
  logic                  par_calc_s;
  logic                  last_edge_s;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
    return (^data) ^ odd;
  endfunction

  // Acceptance-time values and end-of-bit detection.
  always_comb begin
    ps_clamp_s  = (bus.Prescale < 5'd5) ? 5'd5 : bus.Prescale;
    par_calc_s  = calc_parity(bus.P_Data, bus.PAR_TYP);
    last_edge_s = (edge_cnt_r == (ps_r - 5'd1));
  end

  // Transmit FSM with registered line and busy outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= IDLE;
      edge_cnt_r <= 5'd0;
      bit_idx_r  <= '0;
      shift_r    <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      ps_r       <= 5'd0;
      tx_out_r   <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          edge_cnt_r <= 5'd0;
          bit_idx_r  <= '0;
          if (bus.Data_Valid) begin
            shift_r   <= bus.P_Data;
            par_en_r  <= bus.PAR_EN;
            par_bit_r <= par_calc_s;
            ps_r      <= ps_clamp_s;
            state_r   <= START;
            tx_out_r  <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            tx_out_r  <= 1'b1;
            busy_r    <= 1'b0;
          end
        end

        START: begin
          if (last_edge_s) begin
            edge_cnt_r <= 5'd0;
            bit_idx_r  <= '0;
            state_r    <= DATA;
            tx_out_r   <= shift_r[0];
          end else begin
            edge_cnt_r <= edge_cnt_r + 5'd1;
          end
        end

        DATA: begin
          if (last_edge_s) begin
            edge_cnt_r <= 5'd0;
            if (bit_idx_r == LAST_IDX) begin
              if (par_en_r) begin
                state_r  <= PARITY;
                tx_out_r <= par_bit_r;
              end else begin
                state_r  <= STOP;
                tx_out_r <= 1'b1;
              end
            end else begin
              // The shifter keeps the next bit at position 1, so the line
              // updates in the same edge as the index.
              bit_idx_r <= bit_idx_r + 1'b1;
              tx_out_r  <= shift_r[1];
              shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
            end
          end else begin
            edge_cnt_r <= edge_cnt_r + 5'd1;
          end
        end

        PARITY: begin
          if (last_edge_s) begin
            edge_cnt_r <= 5'd0;
            state_r    <= STOP;
            tx_out_r   <= 1'b1;
          end else begin
            edge_cnt_r <= edge_cnt_r + 5'd1;
          end
        end

        STOP: begin
          if (last_edge_s) begin
            edge_cnt_r <= 5'd0;
            bit_idx_r  <= '0;
            if (bus.Data_Valid) begin
              // Back-to-back request: next start bit follows with no gap.
              shift_r   <= bus.P_Data;
              par_en_r  <= bus.PAR_EN;
              par_bit_r <= par_calc_s;
              ps_r      <= ps_clamp_s;
              state_r   <= START;
              tx_out_r  <= 1'b0;
              busy_r    <= 1'b1;
            end else begin
              state_r   <= IDLE;
              tx_out_r  <= 1'b1;
              busy_r    <= 1'b0;
            end
          end else begin
            edge_cnt_r <= edge_cnt_r + 5'd1;
          end
        end

        default: begin
          // Unreachable encoding: return to a quiet idle line.
          state_r    <= IDLE;
          edge_cnt_r <= 5'd0;
          bit_idx_r  <= '0;
          tx_out_r   <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_out_r;
  assign bus.Busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core
// Directed bench for uart_tx_core: every frame is compared cycle by cycle
// against a hand-built bit pattern {stop, [parity], data, start}.
module tb_uart_tx_core;

  logic CLK;
  logic Reset;
  int   checks;
  int   errors;

  uart_tx_core_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle request; returns just after the accepting edge.
  task automatic start_frame(input logic [4:0] ps, input logic [7:0] data,
                             input logic pe, input logic pt);
    bus.Prescale   = ps;
    bus.P_Data     = data;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
  endtask

  // Check a frame already in flight. bits[i] is the i-th transmitted bit.
  // mid_at   : cycle at which a disturbing request/prescale change is applied
  // b2b      : request the 0x3C frame during the last stop cycle
  // abort_at : cycle at which Reset (with Data_Valid) is applied
  task automatic frame_body(input string tag, input logic [10:0] bits, input int nbits,
                            input int ps, input int mid_at, input bit b2b, input int abort_at);
    int total;
    total = nbits * ps;
    for (int k = 0; k < total; k++) begin
      check($sformatf("%s tx k=%0d", tag, k), {31'd0, bus.TX_OUT}, {31'd0, bits[k / ps]});
      check($sformatf("%s busy k=%0d", tag, k), {31'd0, bus.Busy}, 32'd1);
      if (k == abort_at) begin
        Reset          = 1'b1;
        bus.Data_Valid = 1'b1;
        tick();
        Reset          = 1'b0;
        bus.Data_Valid = 1'b0;
        check({tag, " rst tx"}, {31'd0, bus.TX_OUT}, 32'd1);
        check({tag, " rst busy"}, {31'd0, bus.Busy}, 32'd0);
        tick();
        check({tag, " rst idle tx"}, {31'd0, bus.TX_OUT}, 32'd1);
        check({tag, " rst idle busy"}, {31'd0, bus.Busy}, 32'd0);
        return;
      end
      if (k == mid_at) begin
        bus.Data_Valid = 1'b1;
        bus.P_Data     = 8'h3C;
        bus.Prescale   = 5'd20;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b1;
      end
      if (k == mid_at + 1) begin
        bus.Data_Valid = 1'b0;
      end
      if (b2b && (k == total - 1)) begin
        bus.Data_Valid = 1'b1;
        bus.P_Data     = 8'h3C;
        bus.Prescale   = 5'd8;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
      end
      tick();
    end
    if (b2b) begin
      bus.Data_Valid = 1'b0;
      check({tag, " b2b busy"}, {31'd0, bus.Busy}, 32'd1);
      check({tag, " b2b start"}, {31'd0, bus.TX_OUT}, 32'd0);
    end else begin
      check({tag, " end busy"}, {31'd0, bus.Busy}, 32'd0);
      check({tag, " end tx"}, {31'd0, bus.TX_OUT}, 32'd1);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    Reset          = 1'b1;
    bus.Prescale   = 5'd8;
    bus.P_Data     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    tick();
    tick();
    check("reset tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("reset busy", {31'd0, bus.Busy}, 32'd0);
    Reset = 1'b0;
    tick();
    check("idle busy", {31'd0, bus.Busy}, 32'd0);

    // 0xA5, even parity (four ones -> 0), 8 cycles/bit, 88 cycles.
    start_frame(5'd8, 8'hA5, 1'b1, 1'b0);
    frame_body("a5_even", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, -10, 1'b0, -10);
    tick();

    // 0xFF, no parity, 5 cycles/bit: 5 low then 45 high.
    start_frame(5'd5, 8'hFF, 1'b0, 1'b0);
    frame_body("ff_nopar", {1'b0, 1'b1, 8'hFF, 1'b0}, 10, 5, -10, 1'b0, -10);
    tick();

    // Odd parity, 16 cycles/bit: 0x01 -> parity 0, 0x03 -> parity 1.
    start_frame(5'd16, 8'h01, 1'b1, 1'b1);
    frame_body("01_odd", {1'b1, 1'b0, 8'h01, 1'b0}, 11, 16, -10, 1'b0, -10);
    tick();
    start_frame(5'd16, 8'h03, 1'b1, 1'b1);
    frame_body("03_odd", {1'b1, 1'b1, 8'h03, 1'b0}, 11, 16, -10, 1'b0, -10);
    tick();

    // Mid-frame request with 0x3C and Prescale=20: frame must be unaffected.
    start_frame(5'd8, 8'hA5, 1'b1, 1'b0);
    frame_body("a5_mid", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, 40, 1'b0, -10);
    tick();
    check("after mid idle", {31'd0, bus.Busy}, 32'd0);

    // Back-to-back: 0x3C even parity (four ones -> 0) follows with no gap.
    start_frame(5'd8, 8'hA5, 1'b1, 1'b0);
    frame_body("a5_b2b", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, -10, 1'b1, -10);
    frame_body("3c_b2b", {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 8, -10, 1'b0, -10);
    tick();

    // Reset at cycle 30 of a frame, then a clean frame.
    start_frame(5'd8, 8'hA5, 1'b1, 1'b0);
    frame_body("a5_abort", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, -10, 1'b0, 30);
    start_frame(5'd8, 8'hA5, 1'b1, 1'b0);
    frame_body("a5_after", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, -10, 1'b0, -10);
    tick();

    // Prescale 3 is clamped to 5: 0x55 no parity, 50 cycles.
    start_frame(5'd3, 8'h55, 1'b0, 1'b0);
    frame_body("55_clamp", {1'b0, 1'b1, 8'h55, 1'b0}, 10, 5, -10, 1'b0, -10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
UART transmitter. It is the transmit-side counterpart of the Rx oversampling data sampler and uses the same Prescale-based bit timing.
- Accepts a parallel word with a valid strobe.
- Serialises it LSB first as one frame: start bit, data bits, optional parity bit, one stop bit.
- Each bit is held for Prescale clock cycles.
- Sits between the system-side register/FIFO read logic and the serial line.

Parameters:
DATA_WIDTH, 8, number of data bits per frame

Ports:
CLK  input  1  clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Prescale  input  5  clock cycles per serial bit; legal 5..31, values 0..4 treated as 5
P_Data  input  DATA_WIDTH  parallel word to send
Data_Valid  input  1  request strobe; P_Data qualified when high
PAR_EN  input  1  1 = parity bit included in frame
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line; idles high
Busy  output  1  high while a frame is in progress

Behaviour:
- Clock/reset: one clock, CLK. Reset is synchronous and active-high; sampled only on the CLK rising edge.
- Reset values: state=IDLE, bit counter=0, edge counter=0, TX_OUT=1, Busy=0, all holding registers 0. Reset mid-frame aborts the frame; TX_OUT=1 the cycle after the reset edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance: Data_Valid high at a rising edge while state==IDLE.
  - Latches P_Data, PAR_EN, PAR_TYP and clamped Prescale (Ps).
  - Computes parity from the latched data: XOR of bits for even, inverted XOR for odd.
- Later changes to P_Data, PAR_EN, PAR_TYP or Prescale do not affect the frame in flight.
- Data_Valid while Busy is ignored; it is not queued.
- Latency: acceptance at edge N gives TX_OUT=0 and Busy=1 from edge N+1. TX_OUT and Busy are registered outputs.
- Edge counter runs 0..Ps-1 within each bit and wraps to 0 at each bit boundary.
  - Bit changes occur only when edge counter==Ps-1.
- Transitions on edge counter==Ps-1:
  - START -> DATA.
  - DATA -> DATA while bit index < DATA_WIDTH-1; otherwise DATA -> PARITY if PAR_EN else STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Bit order: data sent LSB first; bit index 0..DATA_WIDTH-1.
- Frame length: Ps*(DATA_WIDTH+2+PAR_EN) cycles of Busy=1.
- Back-to-back: Data_Valid high in the last STOP cycle (edge counter==Ps-1) is accepted.
  - Next START begins the following cycle with no idle gap; Busy stays high.
  - Otherwise the state returns to IDLE, Busy=0, TX_OUT=1.
- Line output: TX_OUT=1 in IDLE and STOP, 0 in START, data bit in DATA, parity bit in PARITY. It is glitch-free because it is registered.
- Simultaneous Reset and Data_Valid: Reset wins; the request is dropped.
- Counter widths: edge counter 5 bits, bit index $clog2(DATA_WIDTH) bits. No overflow, since Ps<=31.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, P_Data=0xA5, one-cycle Data_Valid:
  - TX_OUT sequence, each bit 8 cycles: 0,1,0,1,0,0,1,0,1,0(parity),1.
  - Busy high for exactly 88 cycles, starting the cycle after the strobe.
- Prescale=5, PAR_EN=0, P_Data=0xFF: TX_OUT = 0 for 5 cycles, then 1 for 45. Busy high for 50 cycles; no parity slot.
- Odd parity, Prescale=16, P_Data=0x01: parity bit = 0. Repeat with P_Data=0x03: parity bit = 1. Frame 176 cycles.
- Busy-path checks, Prescale=8, 0xA5 frame:
  - Data_Valid pulsed mid-frame with P_Data=0x3C: ignored; 0xA5 frame unchanged.
  - Prescale changed to 20 mid-frame: no effect on bit timing.
  - Data_Valid held high with 0x3C at the last STOP cycle: 0x3C frame starts the next cycle; Busy never drops.
- Reset asserted at cycle 30 of a frame: next cycle TX_OUT=1, Busy=0, state IDLE. A new request after Reset deasserts yields a complete, correct frame.
- Prescale=3, PAR_EN=0, P_Data=0x55: each bit lasts 5 cycles (clamp); frame 50 cycles.
